// File: rtl/nco_pkg.sv
// Shared constants for the NCO PDM output path: default sample width,
// skid FIFO depth/occupancy encoding and the dither LFSR polynomial.
// The LFSR constants are only consumed when NCO_PDM_DITHER_EN is defined.
package nco_pkg;

    localparam int DATA_W_DEF = 16;

    localparam int FIFO_DEPTH = 2;
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 (1-based) map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Fibonacci feedback bit: XOR of the tapped state bits.
    function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/nco_skid_fifo.sv
// Two-entry sample buffer between the NCO and the modulator.
// Entry 0 is always the oldest sample; a pop from a full buffer shifts
// entry 1 down. s_ready comes from the registered occupancy and is held
// low while reset is asserted.
module nco_skid_fifo
    import nco_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic [OCC_W-1:0]         occupancy
);

    logic signed [DATA_W-1:0] mem0;
    logic signed [DATA_W-1:0] mem1;
    logic                     do_push;
    logic                     do_pop;

    assign s_ready = !reset && (occupancy < OCC_FULL);
    assign do_push = s_valid && s_ready;
    assign do_pop  = m_ready && (occupancy != '0);
    assign m_data  = mem0;

    // Occupancy tracking; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Sample storage; contents are don't-care whenever occupancy says empty.
    always_ff @(posedge clk) begin
        if (do_pop) begin
            if (occupancy == OCC_FULL) begin
                mem0 <= mem1;
            end else if (do_push) begin
                mem0 <= s_data;
            end
        end else if (do_push) begin
            if (occupancy == '0) begin
                mem0 <= s_data;
            end else begin
                mem1 <= s_data;
            end
        end
    end

endmodule

// File: rtl/nco_pdm_out.sv
// NCO sample to 1-bit pulse-density output for an IO pad.
// A period counter paces sample consumption from a 2-entry FIFO; a
// first-order accumulator turns the offset-binary sample into a bit stream
// whose density is u / 2^DATA_W.
// Optional feature: define NCO_PDM_DITHER_EN to feed the accumulator
// carry-in from a 16-bit LFSR; otherwise the carry-in is tied to 0.
module nco_pdm_out
    import nco_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         div,
    output logic                     pdm_out,
    output logic                     pdm_oeb,
    output logic                     underrun,
    input  logic                     clr_underrun
);

    // Signed sample to unsigned offset-binary: flip the sign bit.
    function automatic logic [DATA_W-1:0] offset_binary(input logic signed [DATA_W-1:0] s);
        return {~s[DATA_W-1], s[DATA_W-2:0]};
    endfunction

    logic signed [DATA_W-1:0] fifo_data;
    logic [OCC_W-1:0]         fifo_occ;
    logic                     fifo_empty;
    logic [DIV_W-1:0]         count;
    logic                     tick;
    logic                     pop;
    logic signed [DATA_W-1:0] cur_sample;
    logic [DATA_W-1:0]        acc;
    logic [DATA_W-1:0]        u_p0;
    logic [DATA_W:0]          sum_p0;
    logic                     cin;

    nco_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_ready   (pop),
        .m_data    (fifo_data),
        .occupancy (fifo_occ)
    );

    // Emptiness is judged on registered occupancy, so a sample pushed this
    // cycle cannot be consumed by a tick in the same cycle.
    assign fifo_empty = (fifo_occ == '0);
    // ">=" rather than "==" so that lowering div below the running count
    // fires a tick immediately instead of waiting for a wrap.
    assign tick       = enable && (count >= div);
    assign pop        = tick && !fifo_empty;

    // ---- stage p0: offset-binary sample plus accumulator sum ----
    assign u_p0   = offset_binary(cur_sample);
    assign sum_p0 = {1'b0, acc} + {1'b0, u_p0} + {{DATA_W{1'b0}}, cin};

`ifdef NCO_PDM_DITHER_EN
    logic [LFSR_W-1:0] lfsr;

    // Dither source: advances only while the modulator runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (enable) begin
            lfsr <= {lfsr[LFSR_W-2:0], lfsr_feedback(lfsr)};
        end
    end

    assign cin = lfsr[0];
`else
    assign cin = 1'b0;
`endif

    // Sample period counter; parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || tick) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

    // Current sample: replaced by the oldest buffered entry on each tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_sample <= '0;
        end else if (pop) begin
            cur_sample <= fifo_data;
        end
    end

    // ---- stage p1: accumulator, registered carry to the pad ----
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            pdm_out <= 1'b0;
            pdm_oeb <= 1'b1;
        end else if (enable) begin
            acc     <= sum_p0[DATA_W-1:0];
            pdm_out <= sum_p0[DATA_W];
            pdm_oeb <= 1'b0;
        end else begin
            pdm_out <= 1'b0;
            pdm_oeb <= 1'b1;
        end
    end

    // Sticky underrun; a new underrun wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (tick && fifo_empty) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule
